// File: rtl/cmd_proc_pkg.sv
// Shared types and constants for the command processor: FSM states,
// lane dibit encodings, and the mode / read-target select values.
package cmd_proc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Lane encoding: [1] = valid strobe, [0] = serial bit
    localparam logic [1:0] LANE_IDLE = 2'b00;
    localparam logic [1:0] LANE_BIT0 = 2'b10;
    localparam logic [1:0] LANE_BIT1 = 2'b11;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam logic TGT_M1 = 1'b0;
    localparam logic TGT_M2 = 1'b1;

    // Encode one serial bit as a valid lane dibit
    function automatic logic [1:0] lane_dibit(input logic b);
        return b ? LANE_BIT1 : LANE_BIT0;
    endfunction

endpackage

// File: rtl/cmd_processor_btn_sync_edge.sv
// Push-button synchronizer: SYNC_STAGES flop chain giving a clean level,
// plus a rising-edge pulse (level high now, low on the previous cycle).
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Next state: shift the raw input into the chain, remember last level
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and edge-history flops, cleared by the async reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/cmd_processor.sv
// Command processor top: turns switch payload + buttons into a serial
// MSB-first frame on one of three 2-bit lanes (write, read m1, read m2).
// Optional feature macro: CMD_PROC_PARITY_EN appends an even-parity bit.
module cmd_processor
    import cmd_proc_pkg::*;
#(
    parameter int PAYLOAD_W   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PAYLOAD_W-1:0] switch1,
    input  logic                 button1,
    input  logic                 button2,
    input  logic                 button3,
    output logic [1:0]           data_read_m1,
    output logic [1:0]           data_read_m2,
    output logic [1:0]           data_write
);

`ifdef CMD_PROC_PARITY_EN
    localparam int FRAME_LEN = PAYLOAD_W + 1;
`else
    localparam int FRAME_LEN = PAYLOAD_W;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN);
`ifdef CMD_PROC_PARITY_EN
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_W);
`endif

    // Button order in the vectors: [0]=button1, [1]=button2, [2]=button3
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_rise;
    logic       unused_rise;

    assign btn_raw     = {button3, button2, button1};
    assign unused_rise = btn_rise[0] ^ btn_rise[2];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            btn_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk  (clk),
                .reset(reset),
                .din  (btn_raw[gi]),
                .level(btn_level[gi]),
                .rise (btn_rise[gi])
            );
        end
    endgenerate

    state_t                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   mode_q,  mode_d;
    logic                   tgt_q,   tgt_d;
    logic [1:0]             wr_q,    wr_d;
    logic [1:0]             m1_q,    m1_d;
    logic [1:0]             m2_q,    m2_d;
    logic [1:0]             dibit;
`ifdef CMD_PROC_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    // FSM next state: the first bit is emitted on the launch edge itself,
    // so the counter starts at 1 and the lane clears when it hits FRAME_LEN
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        tgt_d   = tgt_q;
        dibit   = LANE_IDLE;
`ifdef CMD_PROC_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (btn_rise[1]) begin
                    state_d = SEND;
                    mode_d  = btn_level[0];
                    tgt_d   = btn_level[2];
                    dibit   = lane_dibit(switch1[PAYLOAD_W-1]);
                    shreg_d = {switch1[PAYLOAD_W-2:0], 1'b0};
                    cnt_d   = CNT_W'(1);
`ifdef CMD_PROC_PARITY_EN
                    parity_d = ^switch1;
`endif
                end
            end
            SEND: begin
                if (cnt_q == FRAME_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef CMD_PROC_PARITY_EN
                    if (cnt_q == PAY_LAST) begin
                        dibit = lane_dibit(parity_q);
                    end else begin
                        dibit   = lane_dibit(shreg_q[PAYLOAD_W-1]);
                        shreg_d = {shreg_q[PAYLOAD_W-2:0], 1'b0};
                    end
`else
                    dibit   = lane_dibit(shreg_q[PAYLOAD_W-1]);
                    shreg_d = {shreg_q[PAYLOAD_W-2:0], 1'b0};
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Steer the dibit onto the lane chosen by the latched mode/target
    always_comb begin
        wr_d = LANE_IDLE;
        m1_d = LANE_IDLE;
        m2_d = LANE_IDLE;
        if (mode_d == MODE_WRITE) begin
            wr_d = dibit;
        end else if (tgt_d == TGT_M1) begin
            m1_d = dibit;
        end else begin
            m2_d = dibit;
        end
    end

    // State and registered lane outputs, aborted immediately by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_READ;
            tgt_q   <= TGT_M1;
            wr_q    <= LANE_IDLE;
            m1_q    <= LANE_IDLE;
            m2_q    <= LANE_IDLE;
`ifdef CMD_PROC_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            tgt_q   <= tgt_d;
            wr_q    <= wr_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
`ifdef CMD_PROC_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign data_write   = wr_q;
    assign data_read_m1 = m1_q;
    assign data_read_m2 = m2_q;

endmodule

// File: tb/tb_cmd_processor.sv
// Testbench for cmd_processor: table-driven frames, hand-written corner
// sequences (held button, re-press, mid-frame reset) and random frames
// checked against a frame model built from the payload bits.
module tb_cmd_processor;

`ifdef CMD_PROC_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] switch1 = 8'h00;
    logic       button1 = 1'b0;
    logic       button2 = 1'b0;
    logic       button3 = 1'b0;
    logic [1:0] data_read_m1;
    logic [1:0] data_read_m2;
    logic [1:0] data_write;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cmd_processor #(.PAYLOAD_W(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .switch1     (switch1),
        .button1     (button1),
        .button2     (button2),
        .button3     (button3),
        .data_read_m1(data_read_m1),
        .data_read_m2(data_read_m2),
        .data_write  (data_write)
    );

    typedef struct {
        logic        mode;
        logic        tgt;
        logic [7:0]  payload;
        int          exp_lane;   // 0 = write, 1 = read m1, 2 = read m2
        logic [15:0] exp_pay;    // payload dibits, first dibit in [15:14]
    } vec_t;

    // Model: frame is {1,bit} per payload bit MSB first, plus optional parity
    function automatic logic [2*FL-1:0] model_frame(input logic [7:0] p);
        logic [2*FL-1:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[2*FL-1-2*i -: 2] = {1'b1, p[7-i]};
        end
`ifdef CMD_PROC_PARITY_EN
        f[1:0] = {1'b1, ^p};
`endif
        return f;
    endfunction

    function automatic int model_lane(input logic m, input logic t);
        if (m) return 0;
        return t ? 2 : 1;
    endfunction

    function automatic logic [5:0] place(input int lane, input logic [1:0] d);
        case (lane)
            0:       return {d, 4'b0000};
            1:       return {2'b00, d, 2'b00};
            default: return {4'b0000, d};
        endcase
    endfunction

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {data_write, data_read_m1, data_read_m2};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: {wr,m1,m2} got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    // press_mode: 0 release early, 1 hold 30 cycles, 2 release and re-press
    // abort_at: frame bit index after which reset is asserted (-1 = none)
    task automatic run_frame(input logic m, input logic t, input logic [7:0] p,
                             input int lane, input logic [2*FL-1:0] seq,
                             input int press_mode, input int abort_at);
        bit aborted = 0;
        @(negedge clk);
        button1 = m;
        button3 = t;
        switch1 = p;
        repeat (4) @(negedge clk);
        button2 = 1'b1;
        @(posedge clk); #1; check("pre_n", 6'b0);
        @(posedge clk); #1; check("pre_n1", 6'b0);
        for (int k = 0; k < FL; k++) begin
            @(posedge clk); #1;
            check($sformatf("bit%0d", k), place(lane, seq[2*FL-1-2*k -: 2]));
            if (k == abort_at) begin
                button2 = 1'b0;
                reset = 1'b0;
                #1; check("async_rst", 6'b0);
                repeat (3) @(negedge clk);
                reset = 1'b1;
                aborted = 1;
                break;
            end
            if (k == 1 && press_mode != 1) button2 = 1'b0;
            if (k == 4 && press_mode == 2) button2 = 1'b1;
            if (k == 5 && press_mode == 2) button2 = 1'b0;
            if (k == 3) begin
                switch1 = ~p;
                button1 = ~m;
                button3 = ~t;
            end
        end
        if (aborted) begin
            for (int i = 0; i < 15; i++) begin
                @(posedge clk); #1; check("post_rst_idle", 6'b0);
            end
        end else begin
            @(posedge clk); #1; check("tail", 6'b0);
            if (press_mode == 1) begin
                for (int i = 0; i < 30; i++) begin
                    @(posedge clk); #1; check("held_idle", 6'b0);
                end
                button2 = 1'b0;
            end
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1; check("idle", 6'b0);
            end
        end
        $display("frame mode=%0d tgt=%0d payload=%02h lane=%0d press=%0d abort=%0d",
                 m, t, p, lane, press_mode, abort_at);
    endtask

    function automatic logic [2*FL-1:0] with_parity(input logic [15:0] pay, input logic [7:0] p);
`ifdef CMD_PROC_PARITY_EN
        return {pay, 1'b1, ^p};
`else
        if (p == 8'h00) return pay;   // keeps p referenced in both builds
        return pay;
`endif
    endfunction

    vec_t tbl[4];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'hAA, 0, 16'hEEEE};
        tbl[1] = '{1'b0, 1'b0, 8'h62, 1, 16'hBEAE};
        tbl[2] = '{1'b0, 1'b1, 8'h0F, 2, 16'hAAFF};
        tbl[3] = '{1'b1, 1'b1, 8'h62, 0, 16'hBEAE};

        // Reset state
        #2; check("in_reset", 6'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1; check("after_reset", 6'b0);

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            run_frame(tbl[i].mode, tbl[i].tgt, tbl[i].payload, tbl[i].exp_lane,
                      with_parity(tbl[i].exp_pay, tbl[i].payload), 0, -1);
        end

        // Held button2: one frame only
        run_frame(1'b0, 1'b1, 8'hC3, 2, model_frame(8'hC3), 1, -1);
        // Re-press during frame is ignored
        run_frame(1'b1, 1'b0, 8'h5A, 0, model_frame(8'h5A), 2, -1);
        // Reset at frame bit 3, then a normal frame recovers
        run_frame(1'b0, 1'b0, 8'hFF, 1, model_frame(8'hFF), 0, 3);
        run_frame(1'b0, 1'b0, 8'h81, 1, model_frame(8'h81), 0, -1);

        // Random frames against the model
        for (int i = 0; i < 20; i++) begin
            logic       rm, rt;
            logic [7:0] rp;
            rm = 1'($urandom_range(0, 1));
            rt = 1'($urandom_range(0, 1));
            rp = 8'($urandom);
            run_frame(rm, rt, rp, model_lane(rm, rt), model_frame(rp), 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
